run_sequencer: RTL and testbench

Parametrised program-counter and run-control unit. It is the successor to the fixed 12-bit PC with hard-coded done at address 128. It sequences instruction fetch from a configurable start address to a configurable end address. It supports relative and absolute jumps, fetch stalls and an explicit halt, and reports through a level req/done handshake with cycle and retired-instruction counters. It sits between the core top level and instr_ROM; branch targets come from the external PC lookup table.

---
 rtl/seq_pkg.sv | 6 +
 rtl/run_sequencer_sat_counter.sv | 18 +
 rtl/run_sequencer.sv | 61 ++++++
 tb/tb_run_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared run-control state encoding and counter saturation constant
package seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CNT_W_DEF = 16;
  localparam logic [63:0] CNT_SAT = '1;
endpackage

// File: rtl/run_sequencer_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter
  import seq_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] MAX = CNT_SAT[W-1:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (en && q != MAX) q <= q + W'(1);
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: program counter and run control with jump, stall, halt and run statistics
module run_sequencer
  import seq_pkg::*;
#(
  parameter int D          = 12,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 128,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic             halt,
  input  logic             jump_en,
  input  logic             jump_rel,
  input  logic [D-1:0]     target,
  output logic [D-1:0]     prog_ctr,
  output logic             fetch_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam logic [D-1:0] START = D'(START_ADDR);
  localparam logic [D-1:0] STOP  = D'(END_ADDR);
  state_t       state, state_nx;
  logic [D-1:0] pc_nx;
  logic         at_end, start_run;
  always_comb begin
    at_end      = prog_ctr == STOP;
    busy        = state == RUN;
    done        = state == DONE;
    fetch_valid = busy && !stall && !at_end;
    start_run   = state == IDLE && req;
    state_nx    = state;
    pc_nx       = prog_ctr;
    case (state)
      IDLE: begin
        state_nx = req ? RUN : IDLE;
        pc_nx    = req ? START : prog_ctr;
      end
      // END_ADDR wins over everything; a stall masks halt and jump
      RUN:
        if (at_end || (!stall && halt)) state_nx = DONE;
        else if (!stall) pc_nx = jump_en ? (jump_rel ? prog_ctr + target : target) : prog_ctr + D'(1);
      DONE: state_nx = req ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      prog_ctr <= START;
    end else begin
      state    <= state_nx;
      prog_ctr <= pc_nx;
    end
  sat_counter #(.W(CNT_W)) u_cycle (.clk(clk), .reset(reset), .clr(start_run), .en(busy), .q(cycle_cnt));
  sat_counter #(.W(CNT_W)) u_instr (.clk(clk), .reset(reset), .clr(start_run), .en(fetch_valid), .q(instr_cnt));
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed runs with a scoreboard of expected fetch addresses and end-of-run counters
module tb_run_sequencer;
  logic        clk = 0, reset = 0, req = 0, stall = 0, halt = 0, jump_en = 0, jump_rel = 0, req_b = 0;
  logic [11:0] target = 0, prog_ctr;
  logic        fetch_valid, busy, done, fetch_valid_b, busy_b, done_b;
  logic [15:0] cycle_cnt, instr_cnt, cycle_cnt_b, instr_cnt_b;
  logic [7:0]  prog_ctr_b;
  logic [11:0] exp_pc[$];
  logic [7:0]  exp_pc_b[$];
  logic [31:0] exp_done[$], exp_done_b[$];
  logic        done_d = 0, done_b_d = 0;
  int          checks = 0, errors = 0;

  run_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .halt(halt), .jump_en(jump_en),
    .jump_rel(jump_rel), .target(target), .prog_ctr(prog_ctr), .fetch_valid(fetch_valid),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  run_sequencer #(.D(8), .START_ADDR(250), .END_ADDR(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .stall(1'b0), .halt(1'b0), .jump_en(1'b0),
    .jump_rel(1'b0), .target(8'd0), .prog_ctr(prog_ctr_b), .fetch_valid(fetch_valid_b),
    .busy(busy_b), .done(done_b), .cycle_cnt(cycle_cnt_b), .instr_cnt(instr_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected entry missing or bound expired", name);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (fetch_valid) begin
        if (exp_pc.size() == 0) miss("fetch_a_unexpected");
        else chk("fetch_a_pc", 32'(prog_ctr), 32'(exp_pc.pop_front()));
      end
      if (fetch_valid_b) begin
        if (exp_pc_b.size() == 0) miss("fetch_b_unexpected");
        else chk("fetch_b_pc", 32'(prog_ctr_b), 32'(exp_pc_b.pop_front()));
      end
      if (done && !done_d) begin
        if (exp_done.size() == 0) miss("done_a_unexpected");
        else chk("done_a_instr_cycle", {instr_cnt, cycle_cnt}, exp_done.pop_front());
      end
      if (done_b && !done_b_d) begin
        if (exp_done_b.size() == 0) miss("done_b_unexpected");
        else chk("done_b_instr_cycle", {instr_cnt_b, cycle_cnt_b}, exp_done_b.pop_front());
      end
    end
    done_d   = done;
    done_b_d = done_b;
  end

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_pc.push_back(12'(i));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [11:0] v);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (prog_ctr == v) return;
    end
    miss("wait_pc");
  endtask

  task automatic wait_done(input bit b);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (b ? done_b : done) return;
    end
    miss("wait_done");
  endtask

  initial begin
    #12;
    chk("rst_pc", 32'(prog_ctr), 0);
    chk("rst_busy_done_fv", {busy, done, fetch_valid}, 0);
    chk("rst_counters", {instr_cnt, cycle_cnt}, 0);
    chk("rst_pc_b", 32'(prog_ctr_b), 250);
    tick();
    reset = 1;
    push_range(0, 127);
    exp_done.push_back({16'd128, 16'd129});
    req = 1;
    wait_done(0);
    chk("done_pc", 32'(prog_ctr), 128);
    req = 0;
    tick();
    chk("idle_busy_done", {busy, done}, 0);
    push_range(0, 127);
    exp_done.push_back({16'd128, 16'd132});
    req = 1;
    wait_pc(5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc", 32'(prog_ctr), 5);
      chk("stall_fv", 32'(fetch_valid), 0);
      tick();
    end
    stall = 0;
    wait_done(0);
    req = 0;
    tick();
    push_range(0, 10);
    push_range(7, 20);
    push_range(100, 127);
    exp_done.push_back({16'd53, 16'd54});
    req = 1;
    wait_pc(10);
    jump_en = 1; jump_rel = 1; target = 12'hFFD;
    tick();
    jump_en = 0;
    chk("jump_rel_pc", 32'(prog_ctr), 7);
    wait_pc(20);
    jump_en = 1; jump_rel = 0; target = 12'd100;
    tick();
    jump_en = 0;
    chk("jump_abs_pc", 32'(prog_ctr), 100);
    wait_done(0);
    req = 0;
    tick();
    push_range(0, 40);
    exp_done.push_back({16'd41, 16'd41});
    req = 1;
    wait_pc(40);
    halt = 1;
    tick();
    halt = 0;
    chk("halt_done", 32'(done), 1);
    repeat (5) tick();
    chk("hold_done_busy", {done, busy}, 2'b10);
    chk("hold_pc", 32'(prog_ctr), 40);
    chk("hold_counters", {instr_cnt, cycle_cnt}, {16'd41, 16'd41});
    req = 0;
    tick();
    chk("drop_idle", {done, busy}, 0);
    push_range(0, 62);
    req = 1;
    tick();
    chk("restart_pc", 32'(prog_ctr), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_counters", {instr_cnt, cycle_cnt}, 0);
    wait_pc(63);
    reset = 0;
    #1;
    chk("async_rst_pc", 32'(prog_ctr), 0);
    chk("async_rst_flags", {busy, done, fetch_valid}, 0);
    chk("async_rst_counters", {instr_cnt, cycle_cnt}, 0);
    req = 0;
    tick();
    reset = 1;
    tick();
    for (int i = 250; i <= 258; i++) exp_pc_b.push_back(8'(i));
    exp_done_b.push_back({16'd9, 16'd10});
    req_b = 1;
    wait_done(1);
    chk("wrap_done_pc_b", 32'(prog_ctr_b), 3);
    req_b = 0;
    tick();
    chk("queues_empty", exp_pc.size() + exp_pc_b.size() + exp_done.size() + exp_done_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
